// File: rtl/paridade_serializer_if.sv
// paridade_serializer_if: valid/ready word handshake feeding the parity serializer
interface paridade_serializer_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] data_in;
    logic             data_valid;
    logic             data_ready;
    modport master (output data_in, data_valid, input data_ready);
    modport slave (input data_in, data_valid, output data_ready);
endinterface

// File: rtl/paridade_serializer.sv
// paridade_serializer: MSB-first word serializer appending an even-parity bit
// Optional frame counter output enabled by PARIDADE_FRAME_COUNT_EN.
module paridade_serializer #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    paridade_serializer_if.slave bus,
    output logic                 out_bit,
    output logic                 frame_start,
    output logic                 frame_end,
    output logic                 busy
`ifdef PARIDADE_FRAME_COUNT_EN
    , output logic [15:0]        frame_count
`endif
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CW-1:0]    cnt;
    logic             par;
    logic             accept;
    assign bus.data_ready = state != SHIFT;
    assign busy           = state != IDLE;
    assign accept         = bus.data_valid && bus.data_ready;
    // The MSB is registered straight onto out_bit at accept, so shreg holds the remaining bits.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            shreg       <= '0;
            cnt         <= '0;
            par         <= 1'b0;
            out_bit     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else if (accept) begin
            state       <= SHIFT;
            shreg       <= bus.data_in << 1;
            par         <= ^bus.data_in;
            cnt         <= '0;
            out_bit     <= bus.data_in[WIDTH-1];
            frame_start <= 1'b1;
            frame_end   <= 1'b0;
        end else if (state == SHIFT) begin
            frame_start <= 1'b0;
            if (cnt == CW'(WIDTH - 1)) begin
                state     <= PARITY;
                out_bit   <= par;
                frame_end <= 1'b1;
            end else begin
                out_bit <= shreg[WIDTH-1];
                shreg   <= shreg << 1;
                cnt     <= cnt + 1'b1;
            end
        end else begin
            state       <= IDLE;
            out_bit     <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end
    end
`ifdef PARIDADE_FRAME_COUNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) frame_count <= '0;
        else if (state == PARITY) frame_count <= frame_count + 16'd1;
    end
`endif
endmodule

// File: tb/tb_paridade_serializer.sv
// tb_paridade_serializer: directed and random frames for WIDTH=8 and WIDTH=1 against a frame-level model
// Frame counter checks are active when PARIDADE_FRAME_COUNT_EN is defined.
module tb_paridade_serializer;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    paridade_serializer_if #(.WIDTH(8)) b8 ();
    paridade_serializer_if #(.WIDTH(1)) b1 ();
    logic ob8, fs8, fe8, bz8, ob1, fs1, fe1, bz1;
`ifdef PARIDADE_FRAME_COUNT_EN
    logic [15:0] fc8, fc1;
`endif

    paridade_serializer #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .bus(b8.slave), .out_bit(ob8),
        .frame_start(fs8), .frame_end(fe8), .busy(bz8)
`ifdef PARIDADE_FRAME_COUNT_EN
        , .frame_count(fc8)
`endif
    );
    paridade_serializer #(.WIDTH(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1.slave), .out_bit(ob1),
        .frame_start(fs1), .frame_end(fe1), .busy(bz1)
`ifdef PARIDADE_FRAME_COUNT_EN
        , .frame_count(fc1)
`endif
    );

    int vectors = 0;
    int errs = 0;
    int frames8 = 0;
    int frames1 = 0;
    logic [31:0] q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int sel, input logic v, input logic [31:0] d);
        if (sel != 0) begin
            b1.data_valid = v;
            b1.data_in    = d[0:0];
        end else begin
            b8.data_valid = v;
            b8.data_in    = d[7:0];
        end
    endtask

    task automatic sample(input int sel, output logic o, output logic fs, output logic fe,
                          output logic bz, output logic rdy);
        o   = sel != 0 ? ob1 : ob8;
        fs  = sel != 0 ? fs1 : fs8;
        fe  = sel != 0 ? fe1 : fe8;
        bz  = sel != 0 ? bz1 : bz8;
        rdy = sel != 0 ? b1.data_ready : b8.data_ready;
    endtask

    task automatic expect_idle(input int sel, input string tag);
        logic o, fs, fe, bz, rdy;
        sample(sel, o, fs, fe, bz, rdy);
        check({tag, ".out_bit"}, 32'(o), 0);
        check({tag, ".frame_start"}, 32'(fs), 0);
        check({tag, ".frame_end"}, 32'(fe), 0);
        check({tag, ".busy"}, 32'(bz), 0);
        check({tag, ".data_ready"}, 32'(rdy), 1);
    endtask

    // Source holds data_valid with the next word at all times; the model predicts a
    // gapless train of WIDTH+1 cycle frames starting the cycle after the first edge.
    task automatic stream(input int sel, input string tag);
        int w = sel != 0 ? 1 : 8;
        int n = q.size();
        int ones = 0;
        logic o, fs, fe, bz, rdy;
        logic [31:0] wm;
        drive(sel, 1'b1, q[0]);
        for (int c = 0; c < n * (w + 1); c++) begin
            int f = c / (w + 1);
            int p = c % (w + 1);
            @(negedge clk);
            if (p == 0) drive(sel, f + 1 < n, f + 1 < n ? q[f+1] : 32'd0);
            wm = q[f] & ((32'd1 << w) - 32'd1);
            sample(sel, o, fs, fe, bz, rdy);
            check($sformatf("%s.f%0d.c%0d.bit", tag, f, p), 32'(o),
                  p < w ? 32'(wm[w-1-p]) : 32'($countones(wm) % 2));
            check($sformatf("%s.f%0d.c%0d.start", tag, f, p), 32'(fs), 32'(p == 0));
            check($sformatf("%s.f%0d.c%0d.end", tag, f, p), 32'(fe), 32'(p == w));
            check($sformatf("%s.f%0d.c%0d.busy", tag, f, p), 32'(bz), 1);
            check($sformatf("%s.f%0d.c%0d.ready", tag, f, p), 32'(rdy), 32'(p == w));
            ones += int'(o);
            if (p == w) begin
                check($sformatf("%s.f%0d.even", tag, f), 32'(ones % 2), 0);
                ones = 0;
            end
        end
        if (sel != 0) frames1 += n; else frames8 += n;
        @(negedge clk);
        expect_idle(sel, {tag, ".idle"});
    endtask

    initial begin
        logic o, fs, fe, bz, rdy;
        drive(0, 1'b0, 0);
        drive(1, 1'b0, 0);
        #3;
        expect_idle(0, "reset8");
        expect_idle(1, "reset1");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        expect_idle(0, "post_reset8");

        q.delete(); q.push_back(32'hA5);
        stream(0, "basic_a5");
        q.delete(); q.push_back(32'h07);
        stream(0, "odd_07");
        q.delete(); q.push_back(32'hFF); q.push_back(32'h01);
        stream(0, "b2b_ff_01");

        // Abort 8'hC3 after three data bits; outputs must drop without a clock edge.
        drive(0, 1'b1, 32'hC3);
        @(negedge clk);
        drive(0, 1'b0, 0);
        sample(0, o, fs, fe, bz, rdy);
        check("abort.bit0", 32'(o), 1);
        check("abort.start", 32'(fs), 1);
        @(negedge clk);
        sample(0, o, fs, fe, bz, rdy);
        check("abort.bit1", 32'(o), 1);
        @(negedge clk);
        sample(0, o, fs, fe, bz, rdy);
        check("abort.bit2", 32'(o), 0);
        #2 reset = 1'b1;
        #1 expect_idle(0, "abort.async");
        @(negedge clk);
        reset = 1'b0;
        q.delete(); q.push_back(32'h3C);
        stream(0, "after_abort_3c");

        for (int r = 0; r < 5; r++) begin
            q.delete();
            for (int k = 0; k < int'($urandom_range(1, 3)); k++) q.push_back($urandom & 32'hFF);
            stream(0, $sformatf("rand8_%0d", r));
        end

        q.delete(); q.push_back(32'h1);
        stream(1, "w1_one");
        q.delete();
        for (int k = 0; k < 4; k++) q.push_back($urandom & 32'h1);
        stream(1, "w1_rand");

`ifdef PARIDADE_FRAME_COUNT_EN
        check("count8", 32'(fc8), 32'(frames8 & 16'hFFFF));
        check("count1", 32'(fc1), 32'(frames1 & 16'hFFFF));
        force dut1.frame_count = 16'hFFFF;
        #1 release dut1.frame_count;
        @(negedge clk);
        check("count1.preload", 32'(fc1), 32'hFFFF);
        q.delete(); q.push_back(32'h0);
        stream(1, "w1_wrap");
        check("count1.wrap", 32'(fc1), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
